// File: rtl/mult32x32_arbiter.sv
// Two-requester round-robin front end for a shared 32x32 multiplier core.
// Each requester holds a level request and receives a one-cycle ack along
// with the 64-bit product. A watchdog turns a core that never raises busy
// into an error response, so a requester is never left waiting forever.
module mult32x32_arbiter #(
  parameter int unsigned WAIT_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic        req1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        ack0,
  output logic        ack1,
  output logic [1:0]  gnt,
  output logic [63:0] result,
  output logic        err,
  output logic        arb_busy,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_busy,
  input  logic [63:0] mul_product
);

  // The watchdog counter is 4 bits wide, so WAIT_LIMIT is limited to 1..15.
  // The timeout fires on the cycle the counter would reach WAIT_LIMIT, which
  // is the same as checking for WAIT_LIMIT-1 before the increment.
  localparam logic [3:0] LIMIT_LAST = 4'(WAIT_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [3:0]  wd_cnt;
  logic [3:0]  wd_cnt_next;
  logic        timeout;
  logic        timeout_next;

  // ptr = 0 gives requester 0 the tie, ptr = 1 gives requester 1 the tie.
  logic        ptr;
  logic        ptr_next;

  logic [1:0]  gnt_next;
  logic [31:0] op_a;
  logic [31:0] op_a_next;
  logic [31:0] op_b;
  logic [31:0] op_b_next;
  logic [63:0] result_next;

  // Requester 1 wins if it is alone, or if both ask and the pointer favours it.
  logic        win1;
  assign win1 = req1 & (~req0 | ptr);

  // State, operand, grant, result and watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wd_cnt  <= 4'd0;
      timeout <= 1'b0;
      ptr     <= 1'b0;
      gnt     <= 2'b00;
      op_a    <= 32'd0;
      op_b    <= 32'd0;
      result  <= 64'd0;
    end else begin
      state   <= state_next;
      wd_cnt  <= wd_cnt_next;
      timeout <= timeout_next;
      ptr     <= ptr_next;
      gnt     <= gnt_next;
      op_a    <= op_a_next;
      op_b    <= op_b_next;
      result  <= result_next;
    end
  end

  // Next-state logic: arbitrate in IDLE, then walk the core handshake.
  always_comb begin
    state_next   = state;
    wd_cnt_next  = wd_cnt;
    timeout_next = timeout;
    ptr_next     = ptr;
    gnt_next     = gnt;
    op_a_next    = op_a;
    op_b_next    = op_b;
    result_next  = result;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          gnt_next     = win1 ? 2'b10 : 2'b01;
          op_a_next    = win1 ? a1 : a0;
          op_b_next    = win1 ? b1 : b0;
          timeout_next = 1'b0;
          state_next   = ISSUE;
        end
      end

      ISSUE: begin
        wd_cnt_next = 4'd0;
        state_next  = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        if (mul_busy) begin
          state_next = WAIT_DONE;
        end else if (wd_cnt == LIMIT_LAST) begin
          timeout_next = 1'b1;
          result_next  = 64'd0;
          state_next   = RESP;
        end else begin
          wd_cnt_next = wd_cnt + 4'd1;
        end
      end

      WAIT_DONE: begin
        if (!mul_busy) begin
          result_next = mul_product;
          state_next  = RESP;
        end
      end

      RESP: begin
        // Hand priority to whichever requester was not just served.
        ptr_next     = gnt[0];
        gnt_next     = 2'b00;
        timeout_next = 1'b0;
        state_next   = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Strobes are decoded from the registered state so they last exactly one cycle.
  always_comb begin
    mul_start = (state == ISSUE);
    ack0      = (state == RESP) && gnt[0];
    ack1      = (state == RESP) && gnt[1];
    err       = (state == RESP) && timeout;
    arb_busy  = (state != IDLE);
    mul_a     = op_a;
    mul_b     = op_b;
  end

endmodule

// File: tb/tb_mult32x32_arbiter.sv
// Directed bench for mult32x32_arbiter with a behavioural multiplier core
// whose busy length is set per step. Expected values are hand-computed.
module tb_mult32x32_arbiter;

  logic        clk;
  logic        reset;
  logic        req0;
  logic [31:0] a0;
  logic [31:0] b0;
  logic        req1;
  logic [31:0] a1;
  logic [31:0] b1;
  logic        ack0;
  logic        ack1;
  logic [1:0]  gnt;
  logic [63:0] result;
  logic        err;
  logic        arb_busy;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_busy;
  logic [63:0] mul_product;

  int          total;
  int          bad;
  int          busy_len;
  logic [3:0]  busy_cnt;

  mult32x32_arbiter #(.WAIT_LIMIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .a0          (a0),
    .b0          (b0),
    .req1        (req1),
    .a1          (a1),
    .b1          (b1),
    .ack0        (ack0),
    .ack1        (ack1),
    .gnt         (gnt),
    .result      (result),
    .err         (err),
    .arb_busy    (arb_busy),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_busy    (mul_busy),
    .mul_product (mul_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural core: busy for busy_len cycles after start; busy_len = 0 never goes busy.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt    <= 4'd0;
      mul_product <= 64'd0;
    end else if (mul_start && busy_len != 0) begin
      busy_cnt    <= 4'(busy_len);
      mul_product <= {32'd0, mul_a} * {32'd0, mul_b};
    end else if (busy_cnt != 4'd0) begin
      busy_cnt <= busy_cnt - 4'd1;
    end
  end
  assign mul_busy = (busy_cnt != 4'd0);

  task automatic applyStimulus(input logic r0, input logic [31:0] av0, input logic [31:0] bv0,
                               input logic r1, input logic [31:0] av1, input logic [31:0] bv1);
    req0 = r0;
    a0   = av0;
    b0   = bv0;
    req1 = r1;
    a1   = av1;
    b1   = bv1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    busy_len = 1;
    reset    = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);

    // Reset state
    @(negedge clk);
    checkOutput("rst_gnt",       64'(gnt),       64'd0);
    checkOutput("rst_ack0",      64'(ack0),      64'd0);
    checkOutput("rst_ack1",      64'(ack1),      64'd0);
    checkOutput("rst_err",       64'(err),       64'd0);
    checkOutput("rst_mul_start", 64'(mul_start), 64'd0);
    checkOutput("rst_arb_busy",  64'(arb_busy),  64'd0);
    checkOutput("rst_result",    result,         64'd0);
    checkOutput("rst_mul_a",     64'(mul_a),     64'd0);
    checkOutput("rst_mul_b",     64'(mul_b),     64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single request, one busy cycle: 3*5 = 0xF, ack0 at T4
    $display("[TB] step: req0 3*5, core busy 1");
    applyStimulus(1'b1, 32'd3, 32'd5, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("t1_start",    64'(mul_start), 64'd1);
    checkOutput("t1_gnt",      64'(gnt),       64'd1);
    checkOutput("t1_mul_a",    64'(mul_a),     64'd3);
    checkOutput("t1_mul_b",    64'(mul_b),     64'd5);
    checkOutput("t1_arb_busy", 64'(arb_busy),  64'd1);
    @(negedge clk);
    checkOutput("t2_start",    64'(mul_start), 64'd0);
    checkOutput("t2_gnt",      64'(gnt),       64'd1);
    @(negedge clk);
    checkOutput("t3_ack0",     64'(ack0),      64'd0);
    checkOutput("t3_gnt",      64'(gnt),       64'd1);
    @(negedge clk);
    checkOutput("t4_ack0",     64'(ack0),      64'd1);
    checkOutput("t4_result",   result,         64'h0F);
    checkOutput("t4_gnt",      64'(gnt),       64'd1);
    checkOutput("t4_err",      64'(err),       64'd0);
    checkOutput("t4_start",    64'(mul_start), 64'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("t5_ack0",     64'(ack0),      64'd0);
    checkOutput("t5_gnt",      64'(gnt),       64'd0);
    checkOutput("t5_arb_busy", 64'(arb_busy),  64'd0);
    checkOutput("t5_result",   result,         64'h0F);

    // Max operands, four busy cycles: ack1 at T7
    $display("[TB] step: req1 max*max, core busy 4");
    busy_len = 4;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checkOutput("max_no_early_ack", 64'(ack1), 64'd0);
    end
    @(negedge clk);
    checkOutput("max_ack1",   64'(ack1), 64'd1);
    checkOutput("max_ack0",   64'(ack0), 64'd0);
    checkOutput("max_result", result,    64'hFFFF_FFFE_0000_0001);
    checkOutput("max_err",    64'(err),  64'd0);
    checkOutput("max_gnt",    64'(gnt),  64'd2);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);

    // Simultaneous requests held: service order 0, 1, 0
    $display("[TB] step: tie, both held");
    busy_len = 1;
    applyStimulus(1'b1, 32'd6, 32'd7, 1'b1, 32'h0001_0000, 32'h0001_0000);
    repeat (4) @(negedge clk);
    checkOutput("tie1_ack0",   64'(ack0), 64'd1);
    checkOutput("tie1_ack1",   64'(ack1), 64'd0);
    checkOutput("tie1_result", result,    64'd42);
    repeat (5) @(negedge clk);
    checkOutput("tie2_ack1",   64'(ack1), 64'd1);
    checkOutput("tie2_ack0",   64'(ack0), 64'd0);
    checkOutput("tie2_result", result,    64'h1_0000_0000);
    repeat (5) @(negedge clk);
    checkOutput("tie3_ack0",   64'(ack0), 64'd1);
    checkOutput("tie3_ack1",   64'(ack1), 64'd0);
    checkOutput("tie3_result", result,    64'd42);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("tie_idle", 64'(arb_busy), 64'd0);

    // Core never goes busy: ack0 and err together five cycles after ISSUE
    $display("[TB] step: watchdog timeout");
    busy_len = 0;
    applyStimulus(1'b1, 32'd9, 32'd9, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("to_issue", 64'(mul_start), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checkOutput("to_no_early_ack", 64'(ack0), 64'd0);
      checkOutput("to_no_early_err", 64'(err),  64'd0);
    end
    @(negedge clk);
    checkOutput("to_ack0",   64'(ack0), 64'd1);
    checkOutput("to_err",    64'(err),  64'd1);
    checkOutput("to_result", result,    64'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("to_err_clear", 64'(err), 64'd0);
    busy_len = 1;
    applyStimulus(1'b1, 32'd4, 32'd4, 1'b0, 32'd0, 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("after_to_ack0",   64'(ack0), 64'd1);
    checkOutput("after_to_err",    64'(err),  64'd0);
    checkOutput("after_to_result", result,    64'd16);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);

    // Reset in WAIT_DONE abandons the transaction
    $display("[TB] step: reset during WAIT_DONE");
    busy_len = 4;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 32'd5, 32'd5);
    repeat (3) @(negedge clk);
    checkOutput("wd_busy_before", 64'(arb_busy), 64'd1);
    checkOutput("wd_gnt_before",  64'(gnt),      64'd2);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_gnt",      64'(gnt),       64'd0);
    checkOutput("mid_rst_arb_busy", 64'(arb_busy),  64'd0);
    checkOutput("mid_rst_ack1",     64'(ack1),      64'd0);
    checkOutput("mid_rst_err",      64'(err),       64'd0);
    checkOutput("mid_rst_start",    64'(mul_start), 64'd0);
    checkOutput("mid_rst_result",   result,         64'd0);
    checkOutput("mid_rst_mul_a",    64'(mul_a),     64'd0);
    checkOutput("mid_rst_mul_b",    64'(mul_b),     64'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("mid_rst_no_ack", 64'(ack1), 64'd0);
    end
    busy_len = 1;
    applyStimulus(1'b1, 32'h1234_5678, 32'h10, 1'b0, 32'd0, 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("post_rst_ack0",   64'(ack0), 64'd1);
    checkOutput("post_rst_result", result,    64'h1_2345_6780);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);

    // Operand change after grant has no effect: 2*3 = 6
    $display("[TB] step: operand latch");
    applyStimulus(1'b1, 32'd2, 32'd3, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("latch_gnt",  64'(gnt),   64'd1);
    checkOutput("latch_a_t1", 64'(mul_a), 64'd2);
    applyStimulus(1'b1, 32'd7, 32'd3, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    checkOutput("latch_a_t2", 64'(mul_a), 64'd2);
    repeat (2) @(negedge clk);
    checkOutput("latch_ack0",   64'(ack0),  64'd1);
    checkOutput("latch_a_t4",   64'(mul_a), 64'd2);
    checkOutput("latch_result", result,     64'd6);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult32x32_arbiter.md
Name: mult32x32_arbiter

Overview:
Shares one 32x32 multiplier core (start/busy handshake, 64-bit product register) between two independent requesters. Each requester uses a level req / pulse ack handshake. The block arbitrates round-robin, latches the winner's operands, pulses the core's start for exactly one cycle, tracks the core's busy, captures the product and returns it with an ack pulse. A watchdog reports a core that never raises busy.

Parameters:
WAIT_LIMIT, 4, max cycles in WAIT_BUSY before a timeout error (1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req0  in  1  requester 0 request (level)
a0  in  32  requester 0 operand A
b0  in  32  requester 0 operand B
req1  in  1  requester 1 request (level)
a1  in  32  requester 1 operand A
b1  in  32  requester 1 operand B
ack0  out  1  one-cycle pulse: requester 0 result valid
ack1  out  1  one-cycle pulse: requester 1 result valid
gnt  out  2  one-hot grant, held from ISSUE through RESP
result  out  64  captured product; held until the next capture
err  out  1  one-cycle pulse coincident with ack on timeout
arb_busy  out  1  high in every state except IDLE
mul_start  out  1  start to the multiplier core
mul_a  out  32  operand A to the core, from the latched register
mul_b  out  32  operand B to the core, from the latched register
mul_busy  in  1  busy from the core
mul_product  in  64  product register of the core

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - gnt=0, ack0=ack1=0, err=0, mul_start=0, arb_busy=0.
  - result=0, mul_a=mul_b=0, watchdog counter=0.
  - Priority pointer set so requester 0 wins the first tie.
  - Reset mid-transaction abandons it with no ack; the core shares the same reset.
- IDLE:
  - If any req is high, pick the winner.
  - Tie: the pointer decides. The pointer flips to the other requester after every completed transaction, including timeouts.
  - Latch the winner's a/b into the operand registers, set gnt, go to ISSUE.
  - Non-winning requests stay pending. A req arriving in another state waits for IDLE.
- ISSUE:
  - mul_start=1 for exactly this cycle (decoded from state).
  - Clear the watchdog counter, go to WAIT_BUSY.
- WAIT_BUSY:
  - If mul_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter.
  - When the counter reaches WAIT_LIMIT, go to RESP with the timeout flag set.
- WAIT_DONE:
  - While mul_busy=1, stay.
  - On mul_busy=0, capture mul_product into result and go to RESP.
- RESP:
  - Pulse ack0 or ack1 (per gnt) for one cycle.
  - If the timeout flag is set: err=1 and result is loaded with 0.
  - Clear gnt at the end of the cycle, flip the pointer, go to IDLE.
- Requester rules:
  - Hold req, a and b stable until ack.
  - Deassert req in the cycle after ack. A req still high in the following IDLE is a new request.
  - Operands are latched, so changing a/b after grant has no effect on the transaction in flight.
- Stability: mul_a and mul_b stay constant from ISSUE through RESP. mul_start is never high outside ISSUE, so the core never re-triggers.
- Latency from req sampled in IDLE (cycle T0) to ack: 3 + (number of cycles mul_busy is high).
  - Core with one busy cycle: ack at T4.
  - Core with four busy cycles: ack at T7.
- Throughput: back-to-back requests from both requesters alternate. Each transaction includes one IDLE cycle.
- Width: products are passed through unmodified (64 bits); there is no truncation.

Test Plan:
- Reset, then req0 with a0=0x0000_0003, b0=0x0000_0005; core busy for 1 cycle -> mul_start high at T1 only; ack0 at T4; result=0x0F; gnt=01 during T1..T4.
- req1 with a1=0xFFFF_FFFF, b1=0xFFFF_FFFF; core busy for 4 cycles -> ack1 at T7; result=0xFFFF_FFFE_0000_0001; err=0.
- req0 and req1 raised in the same cycle, both held -> first service to requester 0, then requester 1, then requester 0 (strict alternation); each ack carries the correct product.
- Stub core that never raises busy, WAIT_LIMIT=4 -> ack0 and err pulse together 5 cycles after ISSUE; result=0; the next request is served normally.
- Assert reset during WAIT_DONE -> all outputs 0 immediately, no ack; a subsequent req0 completes with the correct product.
- Change a0 to 0x7 one cycle after grant (a0=2, b0=3 at grant) -> result=6, proving the operands were latched.
